// File: rtl/ysyx_24080006_ifu.sv
// ysyx_24080006_ifu: instruction fetch front end.
// Owns the fetch PC and keeps at most one ICU request outstanding.
// Responses land in a one-entry buffer that feeds decode over valid/ready.
// Redirects from EXU, including ones that race an in-flight fetch, and
// fence.i sequencing toward the ICU are handled here.
// Optional feature macro: IFU_PERF_CNT_EN enables the fetch and stall
// performance counters. When it is undefined, both counter ports read 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | idle, may issue a request at pc
// S_WAIT  | one request outstanding, its response will be kept
// S_DROP  | one request outstanding, its response will be discarded
// S_FENCE | fencei pulse to the ICU this cycle
module ysyx_24080006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] fetch_addr,
    output logic        ifu2icu_valid,
    output logic        ifu2icu_ready,
    input  logic        icu2ifu_valid,
    input  logic        icu2ifu_ready,
    input  logic [31:0] ic_val,
    output logic        fencei,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fencei_req,
    output logic        if2id_valid,
    input  logic        if2id_ready,
    output logic [31:0] if2id_inst,
    output logic [31:0] if2id_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_FENCE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pend_pc;
    logic [31:0] pend_pc_nxt;
    logic        pend_fence;
    logic        pend_fence_nxt;
    logic        buf_valid;
    logic        buf_load;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign fetch_addr   = pc;
    assign if2id_valid  = buf_valid;
    assign if2id_inst   = buf_inst;
    assign if2id_pc     = buf_pc;

    // State register plus the PC and pending-redirect bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            pend_pc    <= 32'h0;
            pend_fence <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_pc    <= pend_pc_nxt;
            pend_fence <= pend_fence_nxt;
        end
    end

    // Next-state, PC update and ICU-facing outputs.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pend_pc_nxt    = pend_pc;
        pend_fence_nxt = pend_fence;
        ifu2icu_valid  = 1'b0;
        ifu2icu_ready  = 1'b0;
        fencei         = 1'b0;
        buf_load       = 1'b0;
        if (redirect_valid && fencei_req) begin
            pend_fence_nxt = 1'b1;
        end
        case (state)
            S_FETCH: begin
                ifu2icu_valid = !redirect_valid && (!buf_valid || if2id_ready);
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = pend_fence_nxt ? S_FENCE : S_FETCH;
                end else if (ifu2icu_valid && icu2ifu_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                ifu2icu_ready = 1'b1;
                if (icu2ifu_valid) begin
                    // A redirect in the response cycle discards the word directly.
                    if (redirect_valid) begin
                        pc_nxt = redirect_tgt;
                    end else begin
                        buf_load = 1'b1;
                        pc_nxt   = pc + 32'd4;
                    end
                    state_nxt = pend_fence_nxt ? S_FENCE : S_FETCH;
                end else if (redirect_valid) begin
                    // pc must stay put until the ICU answers, so park the target.
                    pend_pc_nxt = redirect_tgt;
                    state_nxt   = S_DROP;
                end
            end
            S_DROP: begin
                ifu2icu_ready = 1'b1;
                if (redirect_valid) begin
                    pend_pc_nxt = redirect_tgt;
                end
                if (icu2ifu_valid) begin
                    pc_nxt    = pend_pc_nxt;
                    state_nxt = pend_fence_nxt ? S_FENCE : S_FETCH;
                end
            end
            S_FENCE: begin
                fencei         = 1'b1;
                pend_fence_nxt = redirect_valid && fencei_req;
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                state_nxt = pend_fence_nxt ? S_FENCE : S_FETCH;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // One-entry output buffer; a redirect flushes it ahead of any handshake.
    always_ff @(posedge clock) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_inst  <= 32'h0;
            buf_pc    <= 32'h0;
        end else begin
            if (buf_load) begin
                buf_inst <= ic_val;
                buf_pc   <= pc;
            end
            if (redirect_valid) begin
                buf_valid <= 1'b0;
            end else if (buf_load) begin
                buf_valid <= 1'b1;
            end else if (buf_valid && if2id_ready) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // The issue rule must keep a response from landing in a full, stalled buffer.
    assert property (@(posedge clock) disable iff (!reset)
        (state == S_WAIT && icu2ifu_valid && !redirect_valid) |-> (!buf_valid || if2id_ready));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Delivered fetches and cycles spent with a request outstanding.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (buf_load) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (state == S_WAIT || state == S_DROP) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_24080006_ifu.sv
// tb_ysyx_24080006_ifu: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level model of the fetch unit
// and a small ICU responder model with programmable latency.
module tb_ysyx_24080006_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch_addr;
    logic        ifu2icu_valid;
    logic        ifu2icu_ready;
    logic        icu2ifu_valid = 1'b0;
    logic        icu2ifu_ready = 1'b0;
    logic [31:0] ic_val = 32'h0;
    logic        fencei;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fencei_req = 1'b0;
    logic        if2id_valid;
    logic        if2id_ready = 1'b0;
    logic [31:0] if2id_inst;
    logic [31:0] if2id_pc;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    always #5 clock = ~clock;

    ysyx_24080006_ifu #(.RESET_PC(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_addr     (fetch_addr),
        .ifu2icu_valid  (ifu2icu_valid),
        .ifu2icu_ready  (ifu2icu_ready),
        .icu2ifu_valid  (icu2ifu_valid),
        .icu2ifu_ready  (icu2ifu_ready),
        .ic_val         (ic_val),
        .fencei         (fencei),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fencei_req     (fencei_req),
        .if2id_valid    (if2id_valid),
        .if2id_ready    (if2id_ready),
        .if2id_inst     (if2id_inst),
        .if2id_pc       (if2id_pc),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: which PC fetches next, whether a request is in flight,
    // whether its answer is to be thrown away, and what decode currently sees.
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    logic        m_out;
    logic        m_discard;
    logic        m_fence_pend;
    logic        m_fence_cycle;
    logic        m_buf_v;
    logic [31:0] m_buf_inst;
    logic [31:0] m_buf_pc;
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_stall_cnt;

    // ICU responder model.
    logic        icu_busy;
    int          icu_cnt;
    int          icu_lat;
    logic        icu_accept;

    task automatic model_reset();
        m_pc          = RST_PC;
        m_pend_pc     = 32'h0;
        m_out         = 1'b0;
        m_discard     = 1'b0;
        m_fence_pend  = 1'b0;
        m_fence_cycle = 1'b0;
        m_buf_v       = 1'b0;
        m_buf_inst    = 32'h0;
        m_buf_pc      = 32'h0;
        m_fetch_cnt   = 32'h0;
        m_stall_cnt   = 32'h0;
        icu_busy      = 1'b0;
        icu_cnt       = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fencei_req     = 1'b0;
        if2id_ready    = 1'b0;
        icu2ifu_valid  = 1'b0;
        icu2ifu_ready  = 1'b0;
        ic_val         = 32'h0;
        @(posedge clock);
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic step(input logic rv, input logic [31:0] rt, input logic fr, input logic dr);
        logic        iv;
        logic        ir;
        logic        req;
        logic        fence_now;
        logic        load;
        logic        out_nxt;
        logic [31:0] iw;
        logic [31:0] tgt;
        @(negedge clock);
        iv = icu_busy && (icu_cnt == 1);
        ir = !icu_busy && icu_accept;
        iw = $urandom;
        reset          = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rt;
        fencei_req     = fr;
        if2id_ready    = dr;
        icu2ifu_valid  = iv;
        icu2ifu_ready  = ir;
        ic_val         = iw;
        #1;
        fence_now = m_fence_cycle;
        req = !m_out && !fence_now && !rv && (!m_buf_v || dr);
        tgt = rt & 32'hffff_fffc;
        check_val("fetch_addr", fetch_addr, m_pc);
        check_val("ifu2icu_valid", {31'b0, ifu2icu_valid}, {31'b0, req});
        check_val("ifu2icu_ready", {31'b0, ifu2icu_ready}, {31'b0, m_out});
        check_val("fencei", {31'b0, fencei}, {31'b0, fence_now});
        check_val("if2id_valid", {31'b0, if2id_valid}, {31'b0, m_buf_v});
        check_val("if2id_inst", if2id_inst, m_buf_inst);
        check_val("if2id_pc", if2id_pc, m_buf_pc);
`ifdef IFU_PERF_CNT_EN
        check_val("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
        check_val("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`else
        check_val("perf_fetch_cnt", perf_fetch_cnt, 32'h0);
        check_val("perf_stall_cnt", perf_stall_cnt, 32'h0);
`endif
        load    = 1'b0;
        out_nxt = m_out;
        if (m_out) begin
            m_stall_cnt = m_stall_cnt + 32'd1;
            if (iv) begin
                out_nxt = 1'b0;
                if (m_discard || rv) begin
                    m_pc = rv ? tgt : m_pend_pc;
                end else begin
                    load = 1'b1;
                end
                m_discard = 1'b0;
            end else if (rv) begin
                m_discard = 1'b1;
                m_pend_pc = tgt;
            end
        end else if (rv) begin
            m_pc = tgt;
        end else if (req && ir) begin
            out_nxt = 1'b1;
        end
        if (load) begin
            m_buf_inst  = iw;
            m_buf_pc    = m_pc;
            m_pc        = m_pc + 32'd4;
            m_fetch_cnt = m_fetch_cnt + 32'd1;
        end
        if (rv) m_buf_v = 1'b0;
        else if (load) m_buf_v = 1'b1;
        else if (m_buf_v && dr) m_buf_v = 1'b0;
        m_fence_pend  = (m_fence_pend && !fence_now) || (rv && fr);
        m_out         = out_nxt;
        m_fence_cycle = !out_nxt && m_fence_pend;
        if (icu_busy) begin
            if (iv) icu_busy = 1'b0;
            else icu_cnt = icu_cnt - 1;
        end else if (req && ir) begin
            icu_busy = 1'b1;
            icu_cnt  = icu_lat;
        end
    endtask

    logic        r_rv;
    logic        r_fr;
    logic        r_dr;
    logic [31:0] r_rt;

    initial begin
        icu_accept = 1'b1;
        icu_lat    = 1;
        model_reset();
        do_reset();

        // Back-to-back hits: one instruction every two cycles.
        step(0, 0, 0, 1);
        check_val("t1_addr0", fetch_addr, 32'h3000_0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_val("t1_addr1", fetch_addr, 32'h3000_0004);
        check_val("t1_pc0", if2id_pc, 32'h3000_0000);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_val("t1_addr2", fetch_addr, 32'h3000_0008);
        check_val("t1_pc1", if2id_pc, 32'h3000_0004);

        // Decode backpressure holds the buffer and blocks issue.
        do_reset();
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check_val("t2_issue_blk", {31'b0, ifu2icu_valid}, 32'h0);
        check_val("t2_pc_hold", fetch_addr, 32'h3000_0004);
        step(0, 0, 0, 0);
        check_val("t2_buf_pc", if2id_pc, 32'h3000_0000);
        icu_lat = 3;
        step(0, 0, 0, 1);
        check_val("t2_issue", {31'b0, ifu2icu_valid}, 32'h1);

        // Redirect while waiting: response is dropped.
        step(1, 32'h8000_0102, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_val("t3_no_out", {31'b0, if2id_valid}, 32'h0);
        icu_lat = 1;
        step(0, 0, 0, 1);
        check_val("t3_tgt", fetch_addr, 32'h8000_0100);

        // Redirect coincident with the response.
        step(1, 32'h8000_1000, 0, 1);
        step(0, 0, 0, 1);
        check_val("t4_no_out", {31'b0, if2id_valid}, 32'h0);
        check_val("t4_tgt", fetch_addr, 32'h8000_1000);
        step(0, 0, 0, 0);
        step(1, 32'h8000_2000, 0, 0);
        check_val("t4_buf_full", {31'b0, if2id_valid}, 32'h1);
        step(0, 0, 0, 0);
        check_val("t4_flushed", {31'b0, if2id_valid}, 32'h0);
        step(0, 0, 0, 0);

        // fence.i while idle.
        step(1, 32'h3000_0040, 1, 0);
        step(0, 0, 0, 1);
        check_val("t5_fencei", {31'b0, fencei}, 32'h1);
        icu_lat = 3;
        step(0, 0, 0, 1);
        check_val("t5_fencei_off", {31'b0, fencei}, 32'h0);
        check_val("t5_tgt", fetch_addr, 32'h3000_0040);

        // fence.i during WAIT pulses only after the dropped response.
        step(1, 32'h3000_0082, 1, 1);
        step(0, 0, 0, 1);
        check_val("t6_no_fence_drop", {31'b0, fencei}, 32'h0);
        step(0, 0, 0, 1);
        check_val("t6_no_fence_resp", {31'b0, fencei}, 32'h0);
        step(0, 0, 0, 1);
        check_val("t6_fencei", {31'b0, fencei}, 32'h1);
        step(0, 0, 0, 1);
        check_val("t6_tgt", fetch_addr, 32'h3000_0080);

        // Reset mid-WAIT.
        step(0, 0, 0, 1);
        do_reset();
        step(0, 0, 0, 1);
        check_val("t7_rst_pc", fetch_addr, RST_PC);
        check_val("t7_rst_buf", {31'b0, if2id_valid}, 32'h0);

        // Ten delivered and two dropped fetches.
        do_reset();
        icu_lat = 1;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1);
            step(0, 0, 0, 1);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1);
            step(1, 32'h3000_0100, 0, 1);
        end
        step(0, 0, 0, 1);
`ifdef IFU_PERF_CNT_EN
        check_val("t8_fetch_cnt", perf_fetch_cnt, 32'd10);
`else
        check_val("t8_fetch_cnt", perf_fetch_cnt, 32'd0);
`endif

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            icu_accept = ($urandom_range(0, 9) < 8);
            icu_lat    = int'($urandom_range(1, 4));
            r_rv = ($urandom_range(0, 9) == 0);
            r_fr = ($urandom_range(0, 3) == 0);
            r_dr = ($urandom_range(0, 9) < 7);
            r_rt = $urandom;
            step(r_rv, r_rt, r_fr, r_dr);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
